// File: rtl/cp0_exc_seq.sv
// CP0 exception sequencer: picks one request per instruction boundary and walks
// it through an ISSUE cycle (exception/eret strobe) and a REDIRECT cycle (PC load).
module cp0_exc_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_done,
    input  logic             syscall_req,
    input  logic             break_req,
    input  logic             teq_req,
    input  logic             eret_req,
    input  logic             ext_intr,
    input  logic [31:0]      status,
    output logic             exception,
    output logic [4:0]       cause,
    output logic             eret,
    output logic             stall,
    output logic             pc_redirect,
    output logic             intr_pending,
    output logic [CNT_W-1:0] exc_cnt
);

    localparam logic [4:0] CAUSE_INT = 5'd0;
    localparam logic [4:0] CAUSE_SYS = 5'd8;
    localparam logic [4:0] CAUSE_BRK = 5'd9;
    localparam logic [4:0] CAUSE_TEQ = 5'd13;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] sel_cause_q, sel_cause_d;
    logic       sel_eret_q, sel_eret_d;
    logic       take_intr;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   intr_rise;

    // Only bit 0 (IE) of Status matters here.
    logic unused_status;
    assign unused_status = ^status[31:1];

    // ------------------------------------------------------------------
    // External interrupt: synchronizer chain, edge detect, pending latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_intr};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign intr_rise = sync_q[SYNC_STAGES-1] & ~edge_q;

    // A fresh edge wins over the clear, so an interrupt arriving in the cycle
    // the previous one is taken is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            intr_pending <= 1'b0;
        end else if (intr_rise) begin
            intr_pending <= 1'b1;
        end else if (take_intr) begin
            intr_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // Contract with the main controller: instr_done is a one-cycle boundary
    // pulse that is only honoured while stall=0; once a request is accepted
    // stall stays high until the PC has loaded the CP0 address.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sel_cause_q <= 5'd0;
            sel_eret_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_cause_q <= sel_cause_d;
            sel_eret_q  <= sel_eret_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_cause_d = sel_cause_q;
        sel_eret_d  = sel_eret_q;
        take_intr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_done) begin
                    if (syscall_req) begin
                        state_d     = ISSUE;
                        sel_cause_d = CAUSE_SYS;
                        sel_eret_d  = 1'b0;
                    end else if (break_req) begin
                        state_d     = ISSUE;
                        sel_cause_d = CAUSE_BRK;
                        sel_eret_d  = 1'b0;
                    end else if (teq_req) begin
                        state_d     = ISSUE;
                        sel_cause_d = CAUSE_TEQ;
                        sel_eret_d  = 1'b0;
                    end else if (eret_req) begin
                        state_d     = ISSUE;
                        sel_cause_d = CAUSE_INT;
                        sel_eret_d  = 1'b1;
                    end else if (intr_pending && status[0]) begin
                        state_d     = ISSUE;
                        sel_cause_d = CAUSE_INT;
                        sel_eret_d  = 1'b0;
                        take_intr   = 1'b1;
                    end
                end
            end
            ISSUE:    state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs decode straight from the state register so reset clears them
    // without waiting for a clock edge.
    always_comb begin
        exception   = 1'b0;
        eret        = 1'b0;
        cause       = 5'd0;
        stall       = 1'b0;
        pc_redirect = 1'b0;
        case (state_q)
            ISSUE: begin
                stall     = 1'b1;
                exception = ~sel_eret_q;
                eret      = sel_eret_q;
                cause     = sel_eret_q ? 5'd0 : sel_cause_q;
            end
            REDIRECT: begin
                stall       = 1'b1;
                pc_redirect = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Exception pulse counter, saturating; eret is not an exception.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_cnt <= '0;
        end else if (exception && (exc_cnt != {CNT_W{1'b1}})) begin
            exc_cnt <= exc_cnt + 1'b1;
        end
    end

endmodule

// File: doc/cp0_exc_seq.md
CP0_EXC_SEQ -- requirements
Module: cp0_exc_seq

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the ext_intr synchronizer depth (legal 2..4).
REQ-003 Parameter CNT_W, default 16, SHALL set the exc_cnt width.
REQ-004 clk  in  1  rising-edge clock shared with the CP0 register file and the main controller.
REQ-005 rst  in  1  asynchronous active-low reset; 0 = reset asserted.
REQ-006 instr_done  in  1  single-cycle pulse in the last cycle of every instruction (instruction boundary).
REQ-007 syscall_req, break_req, teq_req  in  1 each  synchronous-exception flags of the completing instruction, sampled only with instr_done.
REQ-008 eret_req  in  1  completing instruction is ERET, sampled only with instr_done.
REQ-009 ext_intr  in  1  asynchronous external interrupt level.
REQ-010 status  in  32  CP0 Status register; bit 0 = IE.
REQ-011 exception  out  1  one-cycle request to CP0 to enter an exception.
REQ-012 cause  out  5  exception code: 0 interrupt, 8 syscall, 9 break, 13 teq.
REQ-013 eret  out  1  one-cycle request to CP0 to return from an exception.
REQ-014 stall  out  1  holds the main controller while a sequence is in progress.
REQ-015 pc_redirect  out  1  one-cycle strobe: the CP0 exception address is valid, and PC SHALL load it.
REQ-016 intr_pending  out  1  a latched interrupt is waiting.
REQ-017 exc_cnt  out  CNT_W  count of exception pulses issued.

Function
REQ-018 The FSM SHALL have three states: IDLE, ISSUE and REDIRECT.
REQ-019 Transition IDLE->ISSUE SHALL occur on a clk edge where the FSM is in IDLE, instr_done=1 and a request is selected (REQ-020); otherwise the FSM SHALL remain in IDLE.
REQ-020 The request SHALL be selected by fixed priority: syscall_req > break_req > teq_req > eret_req > (intr_pending & status[0]).
REQ-021 In ISSUE, the block SHALL drive exactly one of exception=1 or eret=1 for exactly one cycle, with cause held to the code of the selected request.
REQ-022 cause SHALL be 0 whenever eret=1 or the FSM is in IDLE.
REQ-023 The FSM SHALL pass ISSUE->REDIRECT unconditionally.
REQ-024 REDIRECT SHALL drive pc_redirect=1 for one cycle, then return to IDLE.
REQ-025 Latency: with instr_done in cycle N, ISSUE SHALL occupy cycle N+1, REDIRECT cycle N+2, and IDLE SHALL be re-entered at N+3.
REQ-026 stall SHALL be 1 in ISSUE and REDIRECT and 0 in IDLE.
REQ-027 instr_done and all *_req inputs SHALL be ignored outside IDLE, and ignored in IDLE when instr_done=0.
REQ-028 ext_intr SHALL pass through a SYNC_STAGES flop chain plus an edge-detect flop; a synchronized 0->1 edge SHALL set intr_pending.
REQ-029 With SYNC_STAGES=2, an ext_intr rise before edge N SHALL make intr_pending=1 from cycle N+3.
REQ-030 intr_pending SHALL clear only on the ISSUE entry that selects the interrupt; a new edge arriving that same cycle SHALL leave it set.
REQ-031 A pending interrupt with status[0]=0 SHALL stay pending indefinitely and not be taken.
REQ-032 A synchronous request coinciding with a pending interrupt SHALL be taken first; the interrupt SHALL remain pending for a later boundary.
REQ-033 Multiple simultaneous sync flags SHALL be resolved by REQ-020; lower-priority flags are dropped, not queued.
REQ-034 exc_cnt SHALL increment by 1 on each cycle with exception=1, saturate at all-ones, and not count eret.

Reset
REQ-035 While rst=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, the synchronizer and edge flops SHALL be 0, and intr_pending and exc_cnt SHALL be 0, asynchronously and including mid-sequence.
REQ-036 After rst rises, the first request SHALL be accepted at the first instr_done.

Verification
REQ-037 Syscall: instr_done=1 and syscall_req=1 at cycle 5 -> exception=1 and cause=8 in cycle 6, pc_redirect=1 in cycle 7, stall=1 in cycles 6-7, exc_cnt=1.
REQ-038 Priority: break_req=1 and teq_req=1 with instr_done -> cause=9 only, a single exception pulse, and no second sequence.
REQ-039 Masked interrupt: ext_intr rises with status=0 -> intr_pending=1 and no exception over 20 boundaries; then status=1 -> exception with cause=0 at the next boundary and intr_pending=0.
REQ-040 Collision: intr_pending=1, status=1, syscall_req at a boundary -> cause=8 first, intr_pending stays 1; at the following boundary -> cause=0.
REQ-041 ERET: eret_req with instr_done -> eret=1 for one cycle, exception=0, cause=0, pc_redirect next cycle, exc_cnt unchanged.
REQ-042 Reset in ISSUE: rst=0 during ISSUE -> exception, stall and pc_redirect=0 immediately; intr_pending=0 and exc_cnt=0; no pc_redirect after release.
